// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-requester register port arbiter.
package reg_arb_pkg;

  localparam int REGCOUNT_DEFAULT  = 28;
  localparam int MAX_BURST_DEFAULT = 8;
  localparam int ADDR_W            = 5;

  localparam logic REQ_I2C = 1'b0;
  localparam logic REQ_IO  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/reg_port_arbiter_reg_bank.sv
// Register array: one write port, one registered read port that returns zero when idle,
// and a packed view of every register.
module reg_bank
  import reg_arb_pkg::*;
#(
  parameter int REGCOUNT = REGCOUNT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [7:0]            rd_data,
  output logic [8*REGCOUNT-1:0] regs_packed
);

  logic [7:0] mem_r [REGCOUNT];
  logic [7:0] rd_data_r;

  // Storage update and registered read; reset wins over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGCOUNT; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_data_r <= 8'h00;
    end else begin
      if (wr_en) begin
        mem_r[wr_addr] <= wr_data;
      end else begin
        mem_r[wr_addr] <= mem_r[wr_addr];
      end
      if (rd_en) begin
        rd_data_r <= mem_r[rd_addr];
      end else begin
        rd_data_r <= 8'h00;
      end
    end
  end

  for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
    assign regs_packed[8*g +: 8] = mem_r[g];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/reg_port_arbiter.sv
// Arbitrates two requesters (I2C side, IO side) onto a shared register bank with locked bursts.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of favouring requester 0.
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int REGCOUNT  = REGCOUNT_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [1:0]            lock,
  input  logic [9:0]            addr,
  input  logic [15:0]           wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            ack,
  output logic                  err,
  output logic [7:0]            rdata,
  output logic [8*REGCOUNT-1:0] registers_packed
);

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [ADDR_W:0]    REG_LIMIT = (ADDR_W + 1)'(REGCOUNT);

  arb_state_t         state_r;
  logic               winner_r;
  logic               we_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [7:0]         wdata_r;
  logic [BURST_W-1:0] burst_r;
  logic [1:0]         gnt_r;
  logic [1:0]         ack_r;
  logic               err_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic               last_r;
`endif

  logic               pick_s;
  logic               sel_s;
  logic               cap_we_s;
  logic [ADDR_W-1:0]  cap_addr_s;
  logic [7:0]         cap_wdata_s;
  logic               cont_s;
  logic               in_range_s;
  logic               wr_en_s;
  logic               rd_en_s;

  // Winner for a fresh grant out of IDLE.
  always_comb begin
    pick_s = REQ_I2C;
    if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_s = ~last_r;
`else
      pick_s = REQ_I2C;
`endif
    end else if (req[1]) begin
      pick_s = REQ_IO;
    end else begin
      pick_s = REQ_I2C;
    end
  end

  // A locked continuation recaptures the current winner; otherwise take the fresh pick.
  always_comb begin
    sel_s = pick_s;
    if (state_r == ST_RESP) begin
      sel_s = winner_r;
    end else begin
      sel_s = pick_s;
    end
  end

  assign cap_we_s    = we[sel_s];
  assign cap_addr_s  = sel_s ? addr[9:5] : addr[4:0];
  assign cap_wdata_s = sel_s ? wdata[15:8] : wdata[7:0];
  assign cont_s      = lock[winner_r] & req[winner_r] & (burst_r < BURST_MAX);
  assign in_range_s  = ({1'b0, addr_r} < REG_LIMIT);
  assign wr_en_s     = (state_r == ST_ACCESS) & we_r & in_range_s;
  assign rd_en_s     = (state_r == ST_ACCESS) & ~we_r & in_range_s;

  // Arbitration FSM with registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      winner_r <= REQ_I2C;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= 8'h00;
      burst_r  <= '0;
      gnt_r    <= 2'b00;
      ack_r    <= 2'b00;
      err_r    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_r   <= REQ_IO;
`endif
    end else begin
      gnt_r <= 2'b00;
      ack_r <= 2'b00;
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req != 2'b00) begin
            state_r  <= ST_ACCESS;
            winner_r <= pick_s;
            we_r     <= cap_we_s;
            addr_r   <= cap_addr_s;
            wdata_r  <= cap_wdata_s;
            burst_r  <= BURST_W'(1);
            gnt_r    <= req_onehot(pick_s);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_RESP;
          ack_r   <= req_onehot(winner_r);
          err_r   <= ~in_range_s;
        end
        ST_RESP: begin
          if (cont_s) begin
            state_r <= ST_ACCESS;
            we_r    <= cap_we_s;
            addr_r  <= cap_addr_s;
            wdata_r <= cap_wdata_s;
            burst_r <= burst_r + BURST_W'(1);
            gnt_r   <= req_onehot(winner_r);
          end else begin
            state_r <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_r  <= winner_r;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  reg_bank #(
    .REGCOUNT(REGCOUNT)
  ) u_reg_bank (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en_s),
    .wr_addr    (addr_r),
    .wr_data    (wdata_r),
    .rd_en      (rd_en_s),
    .rd_addr    (addr_r),
    .rd_data    (rdata),
    .regs_packed(registers_packed)
  );

  assign gnt = gnt_r;
  assign ack = ack_r;
  assign err = err_r;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Self-checking bench for reg_port_arbiter: edge-scheduled transaction model plus directed vectors.
module tb_reg_port_arbiter;

  localparam int NREG = 28;
  localparam int MAXB = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req   = 2'b00;
  logic [1:0]    we    = 2'b00;
  logic [1:0]    lock  = 2'b00;
  logic [9:0]    addr  = 10'd0;
  logic [15:0]   wdata = 16'h0000;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic          err;
  logic [7:0]    rdata;
  logic [8*NREG-1:0] registers_packed;

  reg_port_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .registers_packed(registers_packed)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: an access granted at edge t shows gnt after t, ack/err/rdata after t+1,
  // a locked follow-up may be granted at t+2, otherwise fresh arbitration from t+3.
  logic [7:0] mregs [NREG];
  logic [1:0] m_gnt = 2'b00, m_ack = 2'b00;
  logic       m_err = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  int  commit_edge = -1, cont_edge = -1, free_edge = 0, burst = 0;
  logic m_w = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [4:0] m_addr = 5'd0;
  logic [7:0] m_wdata = 8'h00;

  task automatic capture(input logic w);
    m_w     = w;
    m_we    = we[w];
    m_addr  = w ? addr[9:5] : addr[4:0];
    m_wdata = w ? wdata[15:8] : wdata[7:0];
  endtask

  always @(posedge clock) begin
    cyc++;
    m_gnt = 2'b00; m_ack = 2'b00; m_err = 1'b0; m_rdata = 8'h00;
    if (reset) begin
      for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
      m_last = 1'b1; commit_edge = -1; cont_edge = -1; free_edge = cyc + 1; burst = 0;
    end else if (cyc == commit_edge) begin
      m_ack = m_w ? 2'b10 : 2'b01;
      m_err = (int'(m_addr) >= NREG);
      if (!m_err && m_we) mregs[m_addr] = m_wdata;
      else if (!m_err) m_rdata = mregs[m_addr];
      commit_edge = -1; cont_edge = cyc + 1;
    end else if (cyc == cont_edge && lock[m_w] && req[m_w] && burst < MAXB) begin
      capture(m_w);
      burst++;
      m_gnt = m_w ? 2'b10 : 2'b01;
      commit_edge = cyc + 1; cont_edge = -1;
    end else if (cyc == cont_edge) begin
      m_last = m_w; cont_edge = -1; free_edge = cyc + 1;
    end else if (cyc >= free_edge && req != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (req == 2'b11) capture(!m_last);
`else
      if (req == 2'b11) capture(1'b0);
`endif
      else capture(req[1]);
      burst = 1;
      m_gnt = m_w ? 2'b10 : 2'b01;
      commit_edge = cyc + 1; free_edge = 1 << 30;
    end
  end

  function automatic logic [8*NREG-1:0] model_packed();
    logic [8*NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = mregs[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  int ack0_cnt = 0, ack1_cnt = 0, first_ack0 = -1, first_ack1 = -1;
  logic [7:0] first_rd0 = 8'h00, first_rd1 = 8'h00;

  // Per-cycle comparison against the model, plus ack bookkeeping for directed checks.
  always @(negedge clock) begin
    if (cyc > 0) begin
      chk("gnt", 256'(gnt), 256'(m_gnt));
      chk("ack", 256'(ack), 256'(m_ack));
      chk("err", 256'(err), 256'(m_err));
      chk("rdata", 256'(rdata), 256'(m_rdata));
      chk("regs", 256'(registers_packed), 256'(model_packed()));
      if (ack[0]) begin
        ack0_cnt++;
        if (first_ack0 < 0) begin first_ack0 = cyc; first_rd0 = rdata; end
      end
      if (ack[1]) begin
        ack1_cnt++;
        if (first_ack1 < 0) begin first_ack1 = cyc; first_rd1 = rdata; end
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req = r; we = w; lock = l; addr = {a1, a0}; wdata = {d1, d0};
  endtask

  task automatic clear_log();
    ack0_cnt = 0; ack1_cnt = 0; first_ack0 = -1; first_ack1 = -1;
  endtask

  int k;
  logic seen0;

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_gnt", 256'(gnt), 256'(0));
    chk("reset_ack", 256'(ack), 256'(0));
    chk("reset_regs", 256'(registers_packed), 256'(0));
    reset = 1'b0;
    @(negedge clock);

    // Basic write of 0xA5 to register 3 by requester 0.
    drive(2'b01, 2'b01, 2'b00, 5'd3, 5'd0, 8'hA5, 8'h00);
    @(negedge clock);
    chk("t1_gnt", 256'(gnt), 256'(2'b01));
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    @(negedge clock);
    chk("t1_ack", 256'(ack), 256'(2'b01));
    chk("t1_reg3", 256'(registers_packed[31:24]), 256'(8'hA5));
    repeat (3) @(negedge clock);

    // Both requesters read register 3 with req held.
    clear_log();
    drive(2'b11, 2'b00, 2'b00, 5'd3, 5'd3, 8'h00, 8'h00);
    repeat (7) @(negedge clock);
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    repeat (5) @(negedge clock);
    chk("t2_rd0", 256'(first_rd0), 256'(8'hA5));
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_ack_gap", 256'(first_ack1 - first_ack0), 256'(3));
    chk("t2_rd1", 256'(first_rd1), 256'(8'hA5));
`else
    chk("t2_ack1_none", 256'(ack1_cnt), 256'(0));
    chk("t2_ack0_repeat", 256'(ack0_cnt >= 2), 256'(1));
`endif

    // Locked burst by requester 1 writing 0x10+k to addr k; requester 0 waits.
    clear_log();
    k = 0; seen0 = 1'b0;
    drive(2'b10, 2'b10, 2'b10, 5'd0, 5'd0, 8'h00, 8'h10);
    for (int i = 0; i < 80 && !seen0; i++) begin
      @(negedge clock);
      if (gnt == 2'b10) begin
        k++;
        addr[9:5] = 5'(k);
        wdata[15:8] = 8'h10 + 8'(k);
        req[0] = 1'b1;
      end else if (gnt == 2'b01) begin
        seen0 = 1'b1;
      end
    end
    chk("t3_next_winner_req0", 256'(seen0), 256'(1));
    chk("t3_burst_grants", 256'(k), 256'(MAXB));
    chk("t3_burst_acks", 256'(ack1_cnt), 256'(MAXB));
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    repeat (4) @(negedge clock);
    chk("t3_reg7", 256'(registers_packed[63:56]), 256'(8'h17));
    chk("t3_reg8", 256'(registers_packed[71:64]), 256'(8'h00));

    // Out-of-range write.
    drive(2'b01, 2'b01, 2'b00, 5'd28, 5'd0, 8'hFF, 8'h00);
    @(negedge clock);
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    @(negedge clock);
    chk("t4_ack", 256'(ack), 256'(2'b01));
    chk("t4_err", 256'(err), 256'(1));
    chk("t4_rdata", 256'(rdata), 256'(8'h00));
    repeat (3) @(negedge clock);

    // req dropped right after capture, then read back the new value.
    drive(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 8'h3C, 8'h00);
    @(negedge clock);
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    @(negedge clock);
    chk("t5_ack", 256'(ack), 256'(2'b01));
    chk("t5_reg5", 256'(registers_packed[47:40]), 256'(8'h3C));
    @(negedge clock);
    drive(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 8'h00, 8'h00);
    @(negedge clock);
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    @(negedge clock);
    chk("t5_readback", 256'(rdata), 256'(8'h3C));
    repeat (3) @(negedge clock);

    // Reset pulsed while a write is in ACCESS.
    drive(2'b01, 2'b01, 2'b00, 5'd1, 5'd0, 8'h5A, 8'h00);
    @(negedge clock);
    chk("t6_in_access", 256'(gnt), 256'(2'b01));
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_no_ack", 256'(ack), 256'(2'b00));
    reset = 1'b0;
    @(negedge clock);
    chk("t6_reg1", 256'(registers_packed[15:8]), 256'(8'h00));
    drive(2'b01, 2'b00, 2'b00, 5'd1, 5'd0, 8'h00, 8'h00);
    @(negedge clock);
    chk("t6_idle_regrant", 256'(gnt), 256'(2'b01));
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
